// File: rtl/d5m_axis_video_bridge_pkg.sv
// d5m_axis_video_bridge_pkg
// Shared defaults and types for the D5M camera to AXI4-Stream video bridge.
// Contents:
//   DEFAULT_*       default parameter values used by the bridge top
//   bridge_state_t  frame/line tracking state of the bridge
//   axis_beat_t     one stream beat at the default geometry
//                   {tuser, tlast, tdata}; the top packs its FIFO words
//                   in the same bit order for any geometry
package d5m_axis_video_bridge_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_CH     = 3;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    IN_LINE   = 2'd2,
    DROP      = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic                                           tuser;
    logic                                           tlast;
    logic [DEFAULT_DATA_WIDTH*DEFAULT_NUM_CH-1:0]   tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
// Single-clock first-word fall-through FIFO. The head entry lives in a
// registered output stage, the remaining entries in an array read through
// a register, so rd_data is always a flop output.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       push request; taken when not full, or at full with a pop
//   wr_data     word to push
//   rd_en       consumer ready; a pop happens when rd_en and not empty
//   rd_data     head word, valid while empty is low
//   level       total occupancy including the output stage
//   full        level == DEPTH
//   empty       no word presented
module axis_sync_fifo #(
  parameter int  WIDTH = 26,
  parameter int  DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] mem_count_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic pop;
  logic push;
  logic load;
  logic mem_has;
  logic mem_rd;
  logic mem_wr;
  logic bypass;

  assign pop     = out_valid_reg & rd_en;
  assign level   = mem_count_reg + LVL_W'(out_valid_reg);
  assign full    = (level == LVL_W'(DEPTH));
  assign push    = wr_en & (~full | pop);
  // The output stage reloads whenever it is empty or being consumed.
  assign load    = ~out_valid_reg | pop;
  assign mem_has = (mem_count_reg != '0);
  assign mem_rd  = load & mem_has;
  // With nothing stored behind the head, a push goes straight to the output.
  assign bypass  = push & load & ~mem_has;
  assign mem_wr  = push & ~bypass;

  assign rd_data = out_data_reg;
  assign empty   = ~out_valid_reg;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      mem_count_reg <= mem_count_reg + LVL_W'(mem_wr) - LVL_W'(mem_rd);
      if (load) begin
        out_valid_reg <= mem_has | push;
        if (mem_has) begin
          out_data_reg <= mem[rd_ptr_reg];
        end else if (push) begin
          out_data_reg <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/d5m_axis_video_bridge.sv
// d5m_axis_video_bridge
// Converts the raw D5M pixel stream (frame valid, line valid, packed pixel
// data) into AXI4-Stream video with tuser on start of frame and tlast on end
// of line. A one-entry hold register delays each pixel until it is known
// whether it ends a line; a FWFT FIFO absorbs downstream backpressure. When
// a push cannot be accepted the rest of the frame is dropped.
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   pix_fval, pix_lval       camera frame / line valid
//   pix_data                 NUM_CH x DATA_WIDTH pixel
//   m_axis_*                 AXI4-Stream video master
//   clr_status               pulse clearing overflow and drop_count
//   overflow                 sticky pixel-dropped flag
//   drop_count               frames aborted by overflow, saturating
//   frame_count              complete frames accepted, wrapping
//   line_pixels              pixel count of the last completed line
//   frame_lines              line count of the last completed frame
//   fifo_level               current FIFO occupancy
module d5m_axis_video_bridge
  import d5m_axis_video_bridge_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  NUM_CH     = DEFAULT_NUM_CH,
  parameter int  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int  CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  localparam int TDATA_W    = NUM_CH * DATA_WIDTH,
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 pix_fval,
  input  logic                 pix_lval,
  input  logic [TDATA_W-1:0]   pix_data,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [TDATA_W-1:0]   m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  input  logic                 clr_status,
  output logic                 overflow,
  output logic [7:0]           drop_count,
  output logic [15:0]          frame_count,
  output logic [CNT_WIDTH-1:0] line_pixels,
  output logic [CNT_WIDTH-1:0] frame_lines,
  output logic [LEVEL_W-1:0]   fifo_level
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Input sample stage and edge history.
  logic               fval_reg;
  logic               lval_reg;
  logic [TDATA_W-1:0] data_reg;
  logic               fval_prev_reg;
  logic               line_prev_reg;

  logic line_now;
  logic fval_rise;
  logic fval_fall;
  logic line_rise;
  logic line_fall;

  // Lines only count inside a frame, so a frame ending with lval still high
  // produces a line end in the same cycle.
  assign line_now  = fval_reg & lval_reg;
  assign fval_rise = fval_reg & ~fval_prev_reg;
  assign fval_fall = ~fval_reg & fval_prev_reg;
  assign line_rise = line_now & ~line_prev_reg;
  assign line_fall = ~line_now & line_prev_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      fval_reg      <= 1'b0;
      lval_reg      <= 1'b0;
      data_reg      <= '0;
      fval_prev_reg <= 1'b0;
      line_prev_reg <= 1'b0;
    end else begin
      fval_reg      <= pix_fval;
      lval_reg      <= pix_lval;
      data_reg      <= pix_data;
      fval_prev_reg <= fval_reg;
      line_prev_reg <= line_now;
    end
  end

  // Hold stage and push decision.
  bridge_state_t      state_reg;
  bridge_state_t      state_next;
  logic               hold_valid_reg;
  logic               hold_user_reg;
  logic [TDATA_W-1:0] hold_data_reg;
  logic               sof_pending_reg;

  logic               in_frame;
  logic               accept;
  logic               push_req;
  logic               push_ok;
  logic               drop_now;
  logic               fifo_wr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               frame_done;
  logic [TDATA_W+1:0] fifo_wr_data;
  logic [TDATA_W+1:0] fifo_rd_data;

  // A frame is only tracked from a seen fval rise; DROP waits for the next one.
  assign in_frame = (state_reg == WAIT_LINE) || (state_reg == IN_LINE) || fval_rise;
  assign accept   = line_now & in_frame;
  // The held pixel leaves either because a successor arrived or the line ended;
  // the two never coincide because line_fall implies no pixel this cycle.
  assign push_req = hold_valid_reg & (accept | line_fall);
  assign pop      = ~fifo_empty & m_axis_tready;
  assign push_ok  = ~fifo_full | pop;
  assign drop_now = push_req & ~push_ok;
  assign fifo_wr  = push_req & push_ok;

  assign fifo_wr_data = {hold_user_reg, line_fall, hold_data_reg};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hold_valid_reg  <= 1'b0;
      hold_user_reg   <= 1'b0;
      hold_data_reg   <= '0;
      sof_pending_reg <= 1'b0;
    end else begin
      if (drop_now) begin
        hold_valid_reg <= 1'b0;
      end else if (accept) begin
        hold_valid_reg <= 1'b1;
        hold_data_reg  <= data_reg;
        hold_user_reg  <= fval_rise | sof_pending_reg;
      end else if (line_fall) begin
        hold_valid_reg <= 1'b0;
      end

      if (accept) begin
        sof_pending_reg <= 1'b0;
      end else if (fval_rise) begin
        sof_pending_reg <= 1'b1;
      end
    end
  end

  // Frame/line state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    if (drop_now) begin
      state_next = DROP;
    end else begin
      case (state_reg)
        IDLE, DROP: begin
          if (fval_rise) begin
            state_next = line_rise ? IN_LINE : WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (fval_fall) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else if (line_rise) begin
            state_next = IN_LINE;
          end
        end
        IN_LINE: begin
          if (fval_fall) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else if (line_fall) begin
            state_next = WAIT_LINE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Statistics.
  logic [CNT_WIDTH-1:0] pix_cnt_reg;
  logic [CNT_WIDTH-1:0] line_cnt_reg;
  logic [CNT_WIDTH-1:0] line_pixels_reg;
  logic [CNT_WIDTH-1:0] frame_lines_reg;
  logic [15:0]          frame_count_reg;
  logic                 overflow_reg;
  logic [7:0]           drop_count_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pix_cnt_reg     <= '0;
      line_cnt_reg    <= '0;
      line_pixels_reg <= '0;
      frame_lines_reg <= '0;
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
      drop_count_reg  <= '0;
    end else begin
      // The rising cycle already carries the first pixel.
      if (line_rise) begin
        pix_cnt_reg <= CNT_ONE;
      end else if (line_now && (pix_cnt_reg != '1)) begin
        pix_cnt_reg <= pix_cnt_reg + CNT_ONE;
      end

      if (fval_rise) begin
        line_cnt_reg <= line_rise ? CNT_ONE : '0;
      end else if (line_rise && (line_cnt_reg != '1)) begin
        line_cnt_reg <= line_cnt_reg + CNT_ONE;
      end

      if (line_fall) begin
        line_pixels_reg <= pix_cnt_reg;
      end
      if (fval_fall) begin
        frame_lines_reg <= line_cnt_reg;
      end
      if (frame_done) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end

      // A new drop outranks a clear arriving in the same cycle.
      if (drop_now) begin
        overflow_reg <= 1'b1;
        if (clr_status) begin
          drop_count_reg <= 8'd1;
        end else if (drop_count_reg != 8'hFF) begin
          drop_count_reg <= drop_count_reg + 8'd1;
        end
      end else if (clr_status) begin
        overflow_reg   <= 1'b0;
        drop_count_reg <= '0;
      end
    end
  end

  axis_sync_fifo #(
    .WIDTH (TDATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tuser  = fifo_rd_data[TDATA_W+1];
  assign m_axis_tlast  = fifo_rd_data[TDATA_W];
  assign m_axis_tdata  = fifo_rd_data[TDATA_W-1:0];

  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;
  assign frame_count = frame_count_reg;
  assign line_pixels = line_pixels_reg;
  assign frame_lines = frame_lines_reg;

endmodule

// File: tb/tb_d5m_axis_video_bridge.sv
// tb_d5m_axis_video_bridge
// Directed bench for d5m_axis_video_bridge at default geometry
// (8-bit x 3 channels, FIFO depth 16, 12-bit counters).
module tb_d5m_axis_video_bridge;

  localparam int DW    = 8;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int CW    = 12;
  localparam int TW    = DW * NCH;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          pix_fval = 1'b0;
  logic          pix_lval = 1'b0;
  logic [TW-1:0] pix_data = '0;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          clr_status = 1'b0;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [15:0]   frame_count;
  logic [CW-1:0] line_pixels;
  logic [CW-1:0] frame_lines;
  logic [LW-1:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;
  int beat_no     = 0;

  logic [TW+1:0] beat_q[$];

  d5m_axis_video_bridge #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .pix_fval      (pix_fval),
    .pix_lval      (pix_lval),
    .pix_data      (pix_data),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .clr_status    (clr_status),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .frame_count   (frame_count),
    .line_pixels   (line_pixels),
    .frame_lines   (frame_lines),
    .fifo_level    (fifo_level)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change just after the rising edge, so the negedge view equals
  // what the next rising edge transfers.
  always @(negedge ACLK) begin
    if (ARESETN && m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      $display("beat %0d: tdata=%06h tuser=%0b tlast=%0b", beat_no, m_axis_tdata,
               m_axis_tuser, m_axis_tlast);
      beat_no++;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic send_line(input int n, input int base);
    pix_lval = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_data = TW'(base + i);
      step();
    end
    pix_lval = 1'b0;
    step(3);
  endtask

  task automatic send_frame(input int lines, input int ppl, input int base);
    pix_fval = 1'b1;
    step(2);
    for (int l = 0; l < lines; l++) begin
      send_line(ppl, base + l * ppl);
    end
    pix_fval = 1'b0;
    step(3);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (m_axis_tvalid && n < 400) begin
      step();
      n++;
    end
    check(tag, 64'(m_axis_tvalid), 64'd0);
  endtask

  // Beat i must carry data base+i, tuser only on beat 0 (if has_user),
  // tlast exactly where last_mask has a 1.
  task automatic check_beats(input string tag, input int n, input int base,
                             input bit has_user, input logic [63:0] last_mask);
    logic [TW+1:0] exp_beat;
    check({tag, "_count"}, 64'(beat_q.size()), 64'(n));
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      exp_beat = {(has_user && i == 0), last_mask[i], TW'(base + i)};
      check($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_beat));
    end
    beat_q.delete();
  endtask

  initial begin
    int i;

    // Reset state
    step(3);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    ARESETN = 1'b1;
    step(3);

    // 4 lines x 8 pixels, free-running sink
    send_frame(4, 8, 0);
    drain("t1_drain");
    check_beats("t1", 32, 0, 1'b1, 64'h8080_8080);
    check("t1_frame_count", 64'(frame_count), 64'd1);
    check("t1_line_pixels", 64'(line_pixels), 64'd8);
    check("t1_frame_lines", 64'(frame_lines), 64'd4);
    check("t1_overflow", 64'(overflow), 64'd0);

    // three single-pixel lines
    send_frame(3, 1, 100);
    drain("t2_drain");
    check_beats("t2", 3, 100, 1'b1, 64'h7);
    check("t2_frame_count", 64'(frame_count), 64'd2);
    check("t2_line_pixels", 64'(line_pixels), 64'd1);
    check("t2_frame_lines", 64'(frame_lines), 64'd3);

    // stalled sink for a whole 8-pixel line
    m_axis_tready = 1'b0;
    pix_fval = 1'b1;
    step(2);
    send_line(8, 200);
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_overflow", 64'(overflow), 64'd0);
    check("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t3_head", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'({2'b10, TW'(200)}));
    step(4);
    check("t3_head_stable", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
          64'({2'b10, TW'(200)}));
    pix_fval = 1'b0;
    step(3);
    m_axis_tready = 1'b1;
    drain("t3_drain");
    check_beats("t3", 8, 200, 1'b1, 64'h80);
    check("t3_frame_count", 64'(frame_count), 64'd3);

    // 20-pixel line into a stalled 16-deep FIFO
    m_axis_tready = 1'b0;
    pix_fval = 1'b1;
    step(2);
    send_line(20, 300);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_drop_count", 64'(drop_count), 64'd1);
    check("t4_level", 64'(fifo_level), 64'd16);
    pix_fval = 1'b0;
    step(3);
    check("t4_frame_count", 64'(frame_count), 64'd3);
    m_axis_tready = 1'b1;
    drain("t4_drain");
    check_beats("t4", 16, 300, 1'b1, 64'h0);
    send_frame(2, 4, 400);
    drain("t4b_drain");
    check_beats("t4b", 8, 400, 1'b1, 64'h88);
    check("t4b_frame_count", 64'(frame_count), 64'd4);
    check("t4b_overflow_sticky", 64'(overflow), 64'd1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("t4_clr_overflow", 64'(overflow), 64'd0);
    check("t4_clr_drop_count", 64'(drop_count), 64'd0);

    // fval falls while lval is high after the 5th pixel of line 2
    pix_fval = 1'b1;
    step(2);
    send_line(4, 500);
    pix_lval = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pix_data = TW'(504 + p);
      step();
    end
    pix_fval = 1'b0;
    step(2);
    pix_lval = 1'b0;
    step(3);
    drain("t5_drain");
    check_beats("t5", 9, 500, 1'b1, 64'h108);
    check("t5_frame_lines", 64'(frame_lines), 64'd2);
    check("t5_line_pixels", 64'(line_pixels), 64'd5);
    check("t5_frame_count", 64'(frame_count), 64'd5);

    // reset mid-line with 6 beats queued
    m_axis_tready = 1'b0;
    pix_fval = 1'b1;
    step(2);
    pix_lval = 1'b1;
    i = 0;
    while (fifo_level != LW'(6) && i < 30) begin
      pix_data = TW'(600 + i);
      step();
      i++;
    end
    check("t6_level_before", 64'(fifo_level), 64'd6);
    ARESETN = 1'b0;
    #1;
    check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_tdata", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'd0);
    check("t6_frame_count", 64'(frame_count), 64'd0);
    check("t6_line_pixels", 64'(line_pixels), 64'd0);
    check("t6_frame_lines", 64'(frame_lines), 64'd0);
    check("t6_overflow", 64'({overflow, drop_count}), 64'd0);
    step(2);
    pix_fval = 1'b0;
    pix_lval = 1'b0;
    step();
    ARESETN = 1'b1;
    m_axis_tready = 1'b1;
    step(3);
    check("t6_idle_after_release", 64'(m_axis_tvalid), 64'd0);
    beat_q.delete();
    send_frame(1, 3, 700);
    drain("t6_drain");
    check_beats("t6", 3, 700, 1'b1, 64'h4);
    check("t6_frame_count_after", 64'(frame_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
